// File: rtl/shift_rotate_pipe_pkg.sv
// rtl/shift_rotate_pipe_pkg.sv - opcode encodings shared by the shifter and ALU decode
package shift_rotate_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ROL = 3'b000;
  localparam logic [OP_W-1:0] OP_SLL = 3'b001;
  localparam logic [OP_W-1:0] OP_ROR = 3'b010;
  localparam logic [OP_W-1:0] OP_SRL = 3'b011;
  localparam logic [OP_W-1:0] OP_SRA = 3'b100;

  // Opcodes above SRA are reserved; they pass data through and flag an error.
  function automatic logic op_reserved(input logic [OP_W-1:0] op);
    return op > OP_SRA;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one combinational power-of-two shift/rotate step
module shift_stage
  import shift_rotate_pipe_pkg::*;
#(
  parameter int N   = 16,
  parameter int AMT = 1
) (
  input  logic [N-1:0]    x,
  input  logic            en,
  input  logic [OP_W-1:0] op,
  input  logic            sign,
  output logic [N-1:0]    y
);

  // Move the word by AMT positions when this step's count bit is set.
  // sign is the original operand MSB so SRA fills correctly in every step.
  always_comb begin
    y = x;
    if (en) begin
      case (op)
        OP_ROL:  y = {x[N-1-AMT:0], x[N-1:N-AMT]};
        OP_SLL:  y = {x[N-1-AMT:0], {AMT{1'b0}}};
        OP_ROR:  y = {x[AMT-1:0], x[N-1:AMT]};
        OP_SRL:  y = {{AMT{1'b0}}, x[N-1:AMT]};
        OP_SRA:  y = {{AMT{sign}}, x[N-1:AMT]};
        default: y = x;
      endcase
    end
  end

endmodule

// File: rtl/shift_rotate_pipe.sv
// rtl/shift_rotate_pipe.sv - two-stage pipelined shift/rotate unit with valid/ready flow control
module shift_rotate_pipe
  import shift_rotate_pipe_pkg::*;
#(
  parameter int C     = 4,
  parameter int SPLIT = 2,
  localparam int N    = 2 ** C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic [C-1:0]    in_cnt,
  input  logic [OP_W-1:0] in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic            out_err
);

  localparam int HI = C - SPLIT;

  logic            s1_valid;
  logic [N-1:0]    s1_data;
  logic [HI-1:0]   s1_cnt;
  logic [OP_W-1:0] s1_op;
  logic            s1_sign;
  logic            s1_err;
  logic            s2_valid;

  logic            s1_adv;
  logic            s2_adv;

  logic [N-1:0]    s1_chain [SPLIT+1];
  logic [N-1:0]    s2_chain [HI+1];

  // A stage may take new data when it is empty or its contents move on this cycle.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Low-order count bits are resolved before the pipeline register.
  assign s1_chain[0] = in_data;
  for (genvar k = 0; k < SPLIT; k++) begin : g_s1
    shift_stage #(.N(N), .AMT(1 << k)) u_stage (
      .x    (s1_chain[k]),
      .en   (in_cnt[k]),
      .op   (in_op),
      .sign (in_data[N-1]),
      .y    (s1_chain[k+1])
    );
  end

  // High-order count bits are resolved from the stage-1 register.
  assign s2_chain[0] = s1_data;
  for (genvar k = 0; k < HI; k++) begin : g_s2
    shift_stage #(.N(N), .AMT(1 << (SPLIT + k))) u_stage (
      .x    (s2_chain[k]),
      .en   (s1_cnt[k]),
      .op   (s1_op),
      .sign (s1_sign),
      .y    (s2_chain[k+1])
    );
  end

  // Stage 1 register: partial result plus what stage 2 still needs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '0;
      s1_op    <= '0;
      s1_sign  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= s1_chain[SPLIT];
        s1_cnt  <= in_cnt[C-1:SPLIT];
        s1_op   <= in_op;
        s1_sign <= in_data[N-1];
        s1_err  <= op_reserved(in_op);
      end
    end
  end

  // Stage 2 register drives the outputs directly and holds them while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_chain[HI];
        out_err  <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// tb/tb_shift_rotate_pipe.sv - self-checking bench for shift_rotate_pipe
module tb_shift_rotate_pipe;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_in_data;
  logic [4:0]  b_in_cnt;
  logic [2:0]  b_in_op;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [31:0] b_out_data;
  logic        b_out_err;

  int checks = 0;
  int errors = 0;

  shift_rotate_pipe #(.C(4), .SPLIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  shift_rotate_pipe #(.C(5), .SPLIT(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_cnt    (b_in_cnt),
    .in_op     (b_in_op),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_err   (b_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [15:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } res_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Width-generic arithmetic reference: n-bit word held in 64 bits.
  function automatic logic [63:0] ref_model(input logic [63:0] d_in, input int c,
                                            input logic [2:0] op, input int n);
    logic [63:0] mask;
    logic [63:0] d;
    mask = (64'd1 << n) - 64'd1;
    d = d_in & mask;
    case (op)
      3'd0: return ((d << c) | (d >> (n - c))) & mask;
      3'd1: return (d << c) & mask;
      3'd2: return ((d >> c) | (d << (n - c))) & mask;
      3'd3: return d >> c;
      3'd4: return d[n-1] ? ((d >> c) | (mask & ~(mask >> c))) : (d >> c);
      default: return d;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        exp_q [$];
    res_t        r;
    logic [15:0] bp_exp [3];
    logic [15:0] hold_data;
    logic        hold_pending;
    logic        acc_flag;
    int          sent;
    int          got;

    tbl[0]  = '{3'b000, 16'h8001, 4'd1,  16'h0003, 1'b0};
    tbl[1]  = '{3'b001, 16'h8001, 4'd4,  16'h0010, 1'b0};
    tbl[2]  = '{3'b010, 16'h0001, 4'd1,  16'h8000, 1'b0};
    tbl[3]  = '{3'b011, 16'h8000, 4'd15, 16'h0001, 1'b0};
    tbl[4]  = '{3'b100, 16'h8000, 4'd4,  16'hF800, 1'b0};
    tbl[5]  = '{3'b000, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0};
    tbl[6]  = '{3'b001, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0};
    tbl[7]  = '{3'b010, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0};
    tbl[8]  = '{3'b011, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0};
    tbl[9]  = '{3'b100, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0};
    tbl[10] = '{3'b101, 16'h1234, 4'd3,  16'h1234, 1'b1};
    tbl[11] = '{3'b001, 16'hFFFF, 4'd15, 16'h8000, 1'b0};

    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_cnt = '0; b_in_op = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Directed table, one op per cycle, exact two-cycle latency
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("tbl%0d_valid", i - 2), out_valid, 1);
        check($sformatf("tbl%0d_data", i - 2), out_data, tbl[i-2].exp);
        check($sformatf("tbl%0d_err", i - 2), out_err, tbl[i-2].err);
      end else begin
        check($sformatf("latency_early%0d", i), out_valid, 0);
      end
      if (i < 12) begin
        in_valid = 1'b1;
        in_op    = tbl[i].op;
        in_data  = tbl[i].data;
        in_cnt   = tbl[i].cnt;
        check($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("tbl_drained", out_valid, 0);

    // Backpressure: two accepted, third stalled, then drained in order
    out_ready = 1'b0;
    in_op = 3'b001; in_cnt = 4'd1;
    bp_exp[0] = 16'h0002; bp_exp[1] = 16'h0004; bp_exp[2] = 16'h0006;
    in_valid = 1'b1; in_data = 16'h0001;
    #1 check("bp_acc0", in_ready, 1);
    @(negedge clk);
    in_data = 16'h0002;
    #1 check("bp_acc1", in_ready, 1);
    @(negedge clk);
    in_data = 16'h0003;
    #1 check("bp_full", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("bp_stall_ready", in_ready, 0);
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_data", out_data, 16'h0002);
    end
    got = 0;
    acc_flag = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      @(negedge clk);
      if (acc_flag) in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      acc_flag = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp_out%0d", got), out_data, bp_exp[got]);
        got++;
      end
    end
    in_valid = 1'b0;
    check("bp_count", got, 3);
    @(negedge clk);
    #1 check("bp_no_dup", out_valid, 0);

    // Streaming: random ops, random backpressure, scoreboard against the model
    sent = 0; got = 0; acc_flag = 1'b0; hold_pending = 1'b0; hold_data = '0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (acc_flag) in_valid = 1'b0;
      if (!in_valid && sent < 16) begin
        in_valid = 1'b1;
        in_op    = 3'($urandom_range(0, 5));
        in_cnt   = 4'($urandom_range(0, 15));
        in_data  = 16'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (hold_pending) begin
        check("stream_hold_valid", out_valid, 1);
        check("stream_hold_data", out_data, hold_data);
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      acc_flag = in_valid && in_ready;
      if (acc_flag) begin
        r.data = 16'(ref_model(64'(in_data), int'(in_cnt), in_op, 16));
        r.err  = (in_op > 3'b100);
        exp_q.push_back(r);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check($sformatf("stream%0d_data", got), out_data, r.data);
          check($sformatf("stream%0d_err", got), out_err, r.err);
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream_count", got, 16);
    check("stream_leftover", exp_q.size(), 0);

    // Reset mid-flight with both stages full
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b000; in_cnt = 4'd1; in_data = 16'h1111;
    @(negedge clk);
    in_data = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("mid_full_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("post_rst_idle", out_valid, 0);
    end
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b010; in_cnt = 4'd1; in_data = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_lat", out_valid, 0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 16'h8000);

    // 32-bit, single pre-register step
    @(negedge clk);
    check("b_in_ready", b_in_ready, 1);
    b_in_valid = 1'b1; b_in_op = 3'b100; b_in_cnt = 5'd31; b_in_data = 32'h80000000;
    @(negedge clk);
    b_in_op = 3'b000; b_in_cnt = 5'd31; b_in_data = 32'h00000001;
    @(negedge clk);
    b_in_valid = 1'b0;
    check("b_sra_valid", b_out_valid, 1);
    check("b_sra_data", b_out_data, 32'hFFFFFFFF);
    @(negedge clk);
    check("b_rol_valid", b_out_valid, 1);
    check("b_rol_data", b_out_data, 32'h80000000);
    check("b_rol_err", b_out_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
